// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: a valid/ready operand port and a valid/ready
// result port carrying the registered result and its flags.
// master = the side that issues operations and consumes results,
// slave  = the ALU itself.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             zero_flag;
    logic             carry_flag;
    logic             neg_flag;

    modport master (
        output in_valid, A, B, opcode, out_ready,
        input  in_ready, out_valid, R, zero_flag, carry_flag, neg_flag
    );

    modport slave (
        input  in_valid, A, B, opcode, out_ready,
        output in_ready, out_valid, R, zero_flag, carry_flag, neg_flag
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU.
// ADD/SUB/AND/OR/XOR/SLTU (and SHL by 0) complete on the accepting edge;
// SHL by k > 0 takes k cycles, one bit per cycle; MUL is an LSB-first
// shift-add over WIDTH cycles.
// Build option: define ALU_MUL_EN to include the iterative multiplier.
// Without it opcode 111 completes in one cycle with R = 0 and
// carry_flag = 1, marking an unsupported operation.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    // Counter must hold values up to WIDTH (MUL step count).
    localparam int                CW      = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]  WIDTH_W = WIDTH'(WIDTH);
    localparam logic [CW-1:0]     ONE_C   = CW'(1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // a_reg is the shifting operand: shifted value for SHL, multiplicand for MUL.
    logic [WIDTH-1:0] a_reg, a_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    // Registered result and flags; only change when a result is loaded.
    logic [WIDTH-1:0] r_reg, r_next;
    logic             zero_reg, zero_next;
    logic             carry_reg, carry_next;
    logic             neg_reg, neg_next;

`ifdef ALU_MUL_EN
    logic             mul_reg, mul_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] mul_sum;
`endif

    // Single-cycle datapath, evaluated on the live inputs while IDLE.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [CW-1:0]    shamt;
    logic [WIDTH-1:0] quick_r;
    logic             quick_c;
    logic             quick_exec;

    // Result-load strobe from the FSM, with the value and carry to load.
    logic             load;
    logic [WIDTH-1:0] load_r;
    logic             load_c;

    // Combinational result of every op that finishes on the accepting edge.
    always_comb begin
        sum_ext    = {1'b0, bus.A} + {1'b0, bus.B};
        diff_ext   = {1'b0, bus.A} - {1'b0, bus.B};
        shamt      = CW'(bus.B % WIDTH_W);
        quick_r    = '0;
        quick_c    = 1'b0;
        quick_exec = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                quick_r = sum_ext[WIDTH-1:0];
                quick_c = sum_ext[WIDTH];
            end
            OP_SUB: begin
                quick_r = diff_ext[WIDTH-1:0];
                quick_c = diff_ext[WIDTH];      // borrow: A < B unsigned
            end
            OP_AND:  quick_r = bus.A & bus.B;
            OP_OR:   quick_r = bus.A | bus.B;
            OP_XOR:  quick_r = bus.A ^ bus.B;
            OP_SLTU: quick_r = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
            OP_SHL: begin
                if (shamt == '0) begin
                    quick_r = bus.A;
                end else begin
                    quick_exec = 1'b1;
                end
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                quick_exec = 1'b1;
`else
                quick_r = '0;
                quick_c = 1'b1;                 // unsupported-op marker
`endif
            end
            default: quick_r = '0;
        endcase
    end

    // Next-state logic and multi-cycle datapath steps.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        load_r     = '0;
        load_c     = 1'b0;
`ifdef ALU_MUL_EN
        mul_next   = mul_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        mul_sum    = acc_reg + (b_reg[0] ? a_reg : '0);
`endif
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    if (quick_exec) begin
                        state_next = EXEC;
                        a_next     = bus.A;
`ifdef ALU_MUL_EN
                        mul_next   = (bus.opcode == OP_MUL);
                        b_next     = bus.B;
                        acc_next   = '0;
                        cnt_next   = (bus.opcode == OP_MUL) ? CW'(WIDTH) : shamt;
`else
                        cnt_next   = shamt;
`endif
                    end else begin
                        state_next = DONE;
                        load       = 1'b1;
                        load_r     = quick_r;
                        load_c     = quick_c;
                    end
                end
            end
            EXEC: begin
                // Both SHL and MUL shift the A operand left once per step.
                a_next   = a_reg << 1;
                cnt_next = cnt_reg - ONE_C;
                load_r   = a_reg << 1;
`ifdef ALU_MUL_EN
                if (mul_reg) begin
                    acc_next = mul_sum;
                    b_next   = b_reg >> 1;
                    load_r   = mul_sum;
                end
`endif
                if (cnt_reg == ONE_C) begin
                    state_next = DONE;
                    load       = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result and flag update; flags are derived from the value being loaded.
    always_comb begin
        r_next     = r_reg;
        zero_next  = zero_reg;
        carry_next = carry_reg;
        neg_next   = neg_reg;
        if (load) begin
            r_next     = load_r;
            zero_next  = (load_r == '0);
            carry_next = load_c;
            neg_next   = load_r[WIDTH-1];
        end
    end

    // State, datapath and result registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            cnt_reg   <= '0;
            r_reg     <= '0;
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
            neg_reg   <= 1'b0;
`ifdef ALU_MUL_EN
            mul_reg   <= 1'b0;
            b_reg     <= '0;
            acc_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            cnt_reg   <= cnt_next;
            r_reg     <= r_next;
            zero_reg  <= zero_next;
            carry_reg <= carry_next;
            neg_reg   <= neg_next;
`ifdef ALU_MUL_EN
            mul_reg   <= mul_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
`endif
        end
    end

    // Handshake outputs decode the state register only.
    assign bus.in_ready   = (state_reg == IDLE);
    assign bus.out_valid  = (state_reg == DONE);
    assign bus.R          = r_reg;
    assign bus.zero_flag  = zero_reg;
    assign bus.carry_flag = carry_reg;
    assign bus.neg_flag   = neg_reg;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked, multi-cycle ALU for the datapath. It executes the same basic ALU operations at any word width, and adds XOR, left shift and an optional iterative multiply. Operands enter through a valid/ready input port, and results leave through a valid/ready output port with registered zero, carry and negative flags. It is the next-generation drop-in for the execute stage when operations must take more than one cycle.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 2..32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operands and opcode valid.
- `in_ready` out 1: block idle and accepts a new operation.
- `A` in WIDTH: operand A (PC or rd1).
- `B` in WIDTH: operand B (rd2 or Imm).
- `opcode` in 3: operation select.
- `out_valid` out 1: `R` and the flags hold a completed result.
- `out_ready` in 1: consumer takes the result.
- `R` out WIDTH: registered result.
- `zero_flag` out 1: `R == 0`.
- `carry_flag` out 1: carry/borrow.
- `neg_flag` out 1: `R[WIDTH-1]`.

## Operation
- Opcodes:
  - ADD 000
  - SUB 001
  - AND 010
  - OR 011
  - XOR 100
  - SLTU 101: R = 1 if A < B unsigned, else 0
  - SHL 110: R = A << (B mod WIDTH), zero fill
  - MUL 111: low WIDTH bits of A*B, unsigned
- Arithmetic is computed at WIDTH+1 bits.
  - ADD: `carry_flag` = carry-out.
  - SUB: `carry_flag` = borrow, i.e. 1 iff A < B unsigned.
  - All other ops: `carry_flag` = 0.
- `zero_flag` and `neg_flag` are derived from the final `R` and registered with it.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: `in_ready` = 1. When `in_valid` is high, latch A, B and opcode.
    - ADD/SUB/AND/OR/XOR/SLTU, and SHL with shift amount 0: go to DONE.
    - SHL with shift amount > 0, or MUL: go to EXEC.
  - EXEC: SHL shifts one bit per cycle while a down-counter runs from the shift amount. MUL does one shift-add step per cycle for WIDTH cycles (LSB-first over B). The state exits to DONE on the last step.
  - DONE: `out_valid` = 1; `R` and the flags are stable. When `out_ready` is high, go to IDLE.
- `in_ready` is 0 in EXEC and DONE. No new operation is accepted in the same cycle as an output handshake.
- `in_valid` outside IDLE is ignored. Changes to A, B or opcode after acceptance have no effect.
- Asserting `rst` in any state aborts the operation immediately.
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `R` = 0, all flags 0, internal counters 0.

## Timing
- Single-cycle ops: accepted at edge N, so `out_valid` = 1 after edge N+1... more precisely, `out_valid` rises after edge N (DONE is entered at N) and the result is visible in cycle N+1.
- SHL by k > 0: `out_valid` rises after edge N+k.
- MUL: `out_valid` rises after edge N+WIDTH.
- `out_valid` stays high with a constant `R` until the cycle `out_ready` = 1. `in_ready` returns high after that edge.
- Minimum initiation interval is 2 cycles (accept, then handshake out with `out_ready` held high).
- There is no combinational path from `in_valid` or `out_ready` to any output except through the state register.

## Configuration
- `ALU_MUL_EN` defined: MUL is implemented as above, with WIDTH-cycle latency.
- `ALU_MUL_EN` undefined: the multiplier datapath is removed. Opcode 111 then behaves like a single-cycle op:
  - result `R` = 0, `zero_flag` = 1, `carry_flag` = 1, `neg_flag` = 0;
  - `carry_flag` = 1 here marks an unsupported op.

## Test plan
- Reset, then `rst` pulsed mid-MUL in EXEC -> all outputs return to reset values asynchronously; `in_ready` = 1 after deassertion.
- WIDTH=8, ADD 0xF0+0x20 -> `R` = 0x10, `carry_flag` = 1, `zero_flag` = 0, `neg_flag` = 0, `out_valid` one cycle after acceptance. SUB 0x05-0x05 -> `R` = 0, `zero_flag` = 1, `carry_flag` = 0.
- SUB 0x03-0x04 -> `R` = 0xFF, `carry_flag` = 1, `neg_flag` = 1. SLTU 3,4 -> `R` = 1. SLTU 4,3 -> `R` = 0, `zero_flag` = 1.
- SHL A=0x81, B=9 (effective 1) -> `R` = 0x02 after 1 EXEC cycle. SHL B=0 -> single-cycle, `R` = 0x81.
- MUL 0x0C*0x0B with `ALU_MUL_EN` -> `R` = 0x84, `neg_flag` = 1, latency 8. Without the macro -> `R` = 0, `carry_flag` = 1, latency 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles and toggle A, B and `in_valid` -> `R` stays constant, `in_ready` = 0, and no second operation is accepted. Repeat at WIDTH=16 with ADD 0xFFFF+1 -> `R` = 0, `carry_flag` = 1, `zero_flag` = 1.
